// File: rtl/buyruk_bellegi_pkg.sv
// Shared definitions for the instruction-memory responder:
// the NOP word returned on faults/reset and the fetch FSM states.
package buyruk_bellegi_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BEKLE = 2'd1,
        YANIT = 2'd2
    } durum_t;

endpackage

// File: rtl/buyruk_dizisi.sv
// Word storage with one synchronous write port and one enabled synchronous
// read port; a same-edge read of a word being written returns the old data.
module buyruk_dizisi #(
    parameter int DERINLIK = 128,
    parameter int AW       = $clog2(DERINLIK)
) (
    input  logic          clk,
    input  logic          yaz,
    input  logic [AW-1:0] yaz_adres,
    input  logic [31:0]   yaz_veri,
    input  logic          oku,
    input  logic [AW-1:0] oku_adres,
    output logic [31:0]   oku_veri
);

    logic [31:0] mem_r [DERINLIK];

    // Loader write port
    always_ff @(posedge clk) begin
        if (yaz) begin
            mem_r[yaz_adres] <= yaz_veri;
        end else begin
            mem_r[yaz_adres] <= mem_r[yaz_adres];
        end
    end

    // Fetch read port; holds its word between reads
    always_ff @(posedge clk) begin
        if (oku) begin
            oku_veri <= mem_r[oku_adres];
        end else begin
            oku_veri <= oku_veri;
        end
    end

endmodule

// File: rtl/buyruk_bellegi.sv
// Instruction-memory responder: accepts one fetch at a time and returns the
// addressed word (or NOP with hata set) after GECIKME cycles, with backpressure.
module buyruk_bellegi
    import buyruk_bellegi_pkg::*;
#(
    parameter int DERINLIK = 128,
    parameter int GECIKME  = 1,
    localparam int AW      = $clog2(DERINLIK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          istek_gecerli,
    output logic          istek_hazir,
    input  logic [31:0]   ps,
    output logic          yanit_gecerli,
    input  logic          yanit_hazir,
    output logic [31:0]   buyruk,
    output logic          hata,
    input  logic          yukle_gecerli,
    input  logic [AW-1:0] yukle_adres,
    input  logic [31:0]   yukle_veri
);

    localparam int          SW        = (GECIKME > 1) ? $clog2(GECIKME) : 1;
    localparam logic [SW-1:0] SAYAC_YUK = SW'(GECIKME - 1);
    localparam logic [32:0] SINIR     = 33'(DERINLIK) * 33'd4;

    durum_t        durum_r;
    logic [SW-1:0] sayac_r;
    logic [31:0]   ps_r;
    logic          dizi_sec_r;
    logic          kabul_s;
    logic          oku_s;
    logic          hata_s;
    logic [31:0]   kaynak_ps_s;
    logic [31:0]   dizi_veri_s;

    assign istek_hazir = (durum_r == BOSTA) && !rst;
    assign kabul_s     = istek_gecerli && istek_hazir;

    // With GECIKME == 1 the array is read at the accept edge, so the live ps is used there
    always_comb begin
        kaynak_ps_s = ps_r;
        oku_s       = 1'b0;
        if (durum_r == BOSTA) begin
            kaynak_ps_s = ps;
        end else begin
            kaynak_ps_s = ps_r;
        end
        if (GECIKME == 1) begin
            oku_s = kabul_s;
        end else begin
            oku_s = (durum_r == BEKLE) && (sayac_r == '0);
        end
    end

    assign hata_s = (kaynak_ps_s[1:0] != 2'b00) || ({1'b0, kaynak_ps_s} >= SINIR);

    buyruk_dizisi #(
        .DERINLIK (DERINLIK),
        .AW       (AW)
    ) u_dizi (
        .clk       (clk),
        .yaz       (yukle_gecerli),
        .yaz_adres (yukle_adres),
        .yaz_veri  (yukle_veri),
        .oku       (oku_s),
        .oku_adres (kaynak_ps_s[AW+1:2]),
        .oku_veri  (dizi_veri_s)
    );

    // Select is registered alongside the array read, so buyruk only changes at the read edge
    assign buyruk = dizi_sec_r ? dizi_veri_s : NOP;

    // Fetch FSM, wait counter, ps latch and response flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_r       <= BOSTA;
            sayac_r       <= '0;
            ps_r          <= 32'h00000000;
            yanit_gecerli <= 1'b0;
            hata          <= 1'b0;
            dizi_sec_r    <= 1'b0;
        end else begin
            case (durum_r)
                BOSTA: begin
                    if (kabul_s) begin
                        ps_r    <= ps;
                        sayac_r <= SAYAC_YUK;
                        if (GECIKME == 1) begin
                            durum_r       <= YANIT;
                            yanit_gecerli <= 1'b1;
                            hata          <= hata_s;
                            dizi_sec_r    <= !hata_s;
                        end else begin
                            durum_r <= BEKLE;
                        end
                    end else begin
                        durum_r <= BOSTA;
                    end
                end
                BEKLE: begin
                    if (sayac_r == '0) begin
                        durum_r       <= YANIT;
                        yanit_gecerli <= 1'b1;
                        hata          <= hata_s;
                        dizi_sec_r    <= !hata_s;
                    end else begin
                        sayac_r <= sayac_r - SW'(1);
                    end
                end
                YANIT: begin
                    if (yanit_hazir) begin
                        durum_r       <= BOSTA;
                        yanit_gecerli <= 1'b0;
                    end else begin
                        durum_r <= YANIT;
                    end
                end
                default: begin
                    durum_r       <= BOSTA;
                    yanit_gecerli <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buyruk_bellegi.sv
// Bench for buyruk_bellegi: four instances with GECIKME 1..4, a reference
// word model per instance and a scoreboard of expected {hata, buyruk}.
module tb_buyruk_bellegi;

    localparam logic [31:0] NOP_K = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        istek_gecerli [4];
    logic        istek_hazir   [4];
    logic [31:0] ps            [4];
    logic        yanit_gecerli [4];
    logic        yanit_hazir   [4];
    logic [31:0] buyruk        [4];
    logic        hata          [4];
    logic        yukle_gecerli [4];
    logic [6:0]  yukle_adres   [4];
    logic [31:0] yukle_veri    [4];

    logic [31:0] mdl [4][128];
    logic [32:0] sb [$];
    int          checks;
    int          failures;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        buyruk_bellegi #(
            .DERINLIK (128),
            .GECIKME  (g + 1)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .istek_gecerli (istek_gecerli[g]),
            .istek_hazir   (istek_hazir[g]),
            .ps            (ps[g]),
            .yanit_gecerli (yanit_gecerli[g]),
            .yanit_hazir   (yanit_hazir[g]),
            .buyruk        (buyruk[g]),
            .hata          (hata[g]),
            .yukle_gecerli (yukle_gecerli[g]),
            .yukle_adres   (yukle_adres[g]),
            .yukle_veri    (yukle_veri[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
        checks++;
        if (gozlenen !== beklenen) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    function automatic logic [32:0] beklenen(input int k, input logic [31:0] p);
        logic h;
        h = (p[1:0] != 2'b00) || (p >= 32'd512);
        return {h, h ? NOP_K : mdl[k][p[8:2]]};
    endfunction

    task automatic yukle(input int k, input int idx, input logic [31:0] v);
        @(negedge clk);
        yukle_gecerli[k] = 1'b1;
        yukle_adres[k]   = 7'(idx);
        yukle_veri[k]    = v;
        mdl[k][idx]      = v;
        @(negedge clk);
        yukle_gecerli[k] = 1'b0;
    endtask

    // One fetch on instance k (GECIKME = k+1); dur = stall cycles, carp = loader hits the read edge
    task automatic getir(input int k, input logic [31:0] p, input int dur, input bit carp);
        int          e;
        int          gec;
        logic [32:0] bek;
        logic [31:0] ilk;
        gec = (k == 0) ? 0 : k + 1;
        @(negedge clk);
        kontrol("hazir_once", 64'(istek_hazir[k]), 64'(1'b1));
        istek_gecerli[k] = 1'b1;
        ps[k]            = p;
        yanit_hazir[k]   = (dur == 0);
        @(posedge clk);
        sb.push_back(beklenen(k, p));
        @(negedge clk);
        istek_gecerli[k] = 1'b0;
        ps[k]            = p + 32'd4;
        e = 0;
        while (!yanit_gecerli[k] && e < 20) begin
            kontrol("hazir_bekle", 64'(istek_hazir[k]), 64'(1'b0));
            if (carp && e == k) begin
                yukle_gecerli[k] = 1'b1;
                yukle_adres[k]   = p[8:2];
                yukle_veri[k]    = 32'hFFFFFFFF;
                mdl[k][p[8:2]]   = 32'hFFFFFFFF;
            end
            @(negedge clk);
            yukle_gecerli[k] = 1'b0;
            e++;
        end
        kontrol("gecikme", 64'(e), 64'(gec));
        ilk = buyruk[k];
        kontrol("sb_dolu", 64'(sb.size() != 0), 64'(1'b1));
        bek = (sb.size() != 0) ? sb.pop_front() : 33'h0;
        kontrol("buyruk", 64'(buyruk[k]), 64'(bek[31:0]));
        kontrol("hata", 64'(hata[k]), 64'(bek[32]));
        for (int i = 0; i < dur; i++) begin
            istek_gecerli[k] = 1'b1;
            ps[k]            = p + 32'd8;
            @(negedge clk);
            kontrol("tut_gecerli", 64'(yanit_gecerli[k]), 64'(1'b1));
            kontrol("tut_buyruk", 64'(buyruk[k]), 64'(ilk));
            kontrol("tut_hata", 64'(hata[k]), 64'(bek[32]));
            kontrol("tut_hazir", 64'(istek_hazir[k]), 64'(1'b0));
        end
        istek_gecerli[k] = 1'b0;
        yanit_hazir[k]   = 1'b1;
        @(negedge clk);
        kontrol("sonra_hazir", 64'(istek_hazir[k]), 64'(1'b1));
        kontrol("sonra_gecerli", 64'(yanit_gecerli[k]), 64'(1'b0));
        yanit_hazir[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            istek_gecerli[k] = 1'b0;
            ps[k]            = 32'h0;
            yanit_hazir[k]   = 1'b0;
            yukle_gecerli[k] = 1'b0;
            yukle_adres[k]   = 7'h0;
            yukle_veri[k]    = 32'h0;
            for (int i = 0; i < 128; i++) mdl[k][i] = 32'h0;
        end
        #3;
        for (int k = 0; k < 4; k++) begin
            kontrol("rst_hazir", 64'(istek_hazir[k]), 64'(1'b0));
            kontrol("rst_gecerli", 64'(yanit_gecerli[k]), 64'(1'b0));
            kontrol("rst_buyruk", 64'(buyruk[k]), 64'(NOP_K));
            kontrol("rst_hata", 64'(hata[k]), 64'(1'b0));
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // GECIKME = 1: load check, error cases, top word
        yukle(0, 1, 32'h00508093);
        yukle(0, 127, 32'hCAFE0037);
        getir(0, 32'd4, 0, 1'b0);
        getir(0, 32'd6, 0, 1'b0);
        getir(0, 32'd512, 0, 1'b0);
        getir(0, 32'd508, 0, 1'b0);

        // GECIKME = 3: ps latch plus backpressure
        yukle(2, 2, 32'h00C00113);
        yukle(2, 3, 32'h00D00193);
        getir(2, 32'd8, 4, 1'b0);
        getir(2, 32'd12, 0, 1'b0);

        // GECIKME = 2: loader collides with the read edge
        yukle(1, 3, 32'h00100663);
        getir(1, 32'd12, 0, 1'b1);
        getir(1, 32'd12, 0, 1'b0);

        // GECIKME = 4: reset in the middle of BEKLE
        yukle(3, 5, 32'h12345678);
        getir(3, 32'd20, 0, 1'b0);
        @(negedge clk);
        istek_gecerli[3] = 1'b1;
        ps[3]            = 32'd20;
        yanit_hazir[3]   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        istek_gecerli[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        kontrol("orta_rst_gecerli", 64'(yanit_gecerli[3]), 64'(1'b0));
        kontrol("orta_rst_buyruk", 64'(buyruk[3]), 64'(NOP_K));
        kontrol("orta_rst_hata", 64'(hata[3]), 64'(1'b0));
        kontrol("orta_rst_hazir", 64'(istek_hazir[3]), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            kontrol("rst_sonra_hazir", 64'(istek_hazir[3]), 64'(1'b1));
            kontrol("rst_sonra_bayat", 64'(yanit_gecerli[3]), 64'(1'b0));
        end
        yanit_hazir[3] = 1'b0;
        getir(3, 32'd20, 0, 1'b0);
        getir(0, 32'd4, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
